tr_defuzzy_seq: RTL

// - Parametrised, multicycle centroid defuzzifier for the interval type-2 trapezoidal controller.
// - Per set i: FOU_i = up_i + low_i. Output = sum(FOU_i*pos_i) / sum(FOU_i).
// - Inputs are captured on start. One set is accumulated per cycle, then a sequential restoring divider runs.
// - Sits after rule inference; replaces the fixed 3-set combinational divider and output register.

---
 rtl/tr_defuzzy_seq.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/tr_defuzzy_seq.sv
// Multicycle centroid defuzzifier: accumulates one fuzzy set per cycle, then restoring-divides NUM/DEN.
// Optional round-half-up result when TR_DEFUZZY_ROUND_EN is defined (default build truncates).
module tr_defuzzy_seq #(
  parameter int N_SETS = 3,
  parameter int W      = 8,
  parameter int POS_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [N_SETS*W-1:0]       fou_up,
  input  logic [N_SETS*W-1:0]       fou_low,
  input  logic [N_SETS*POS_W-1:0]   pos,
  output logic                      busy,
  output logic                      valid,
  output logic                      div_zero,
  output logic [POS_W-1:0]          saida
);

  localparam int LG_N = $clog2(N_SETS);
  localparam int SW   = W + 1;
  localparam int PW   = W + 1 + POS_W;
  localparam int DW   = W + 1 + LG_N;
  localparam int NW   = W + 1 + POS_W + LG_N;
`ifdef TR_DEFUZZY_ROUND_EN
  localparam int DIV_CYC = POS_W + 1;
`else
  localparam int DIV_CYC = POS_W;
`endif
  localparam int CNT_MAX = (N_SETS > DIV_CYC) ? N_SETS : DIV_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DIV, DONE} state_t;

  state_t                    state_r;
  logic [N_SETS*W-1:0]       up_r;
  logic [N_SETS*W-1:0]       low_r;
  logic [N_SETS*POS_W-1:0]   pos_r;
  logic [NW-1:0]             num_r;
  logic [DW-1:0]             den_r;
  logic [DW-1:0]             rem_r;
  logic [POS_W-1:0]          lo_r;
  logic [POS_W-1:0]          quo_r;
  logic [CW-1:0]             cnt_r;
  logic                      busy_r;
  logic                      valid_r;
  logic                      div_zero_r;
  logic [POS_W-1:0]          saida_r;

  logic [SW-1:0]             sum_s;
  logic [PW-1:0]             prod_s;
  logic [NW-1:0]             num_nx_s;
  logic [DW-1:0]             den_nx_s;
  logic [DW:0]               trial_s;
  logic                      ge_s;
  logic                      accept_s;
`ifdef TR_DEFUZZY_ROUND_EN
  logic                      rnd_s;
`endif

  // Per-set weight/product for the current set index and one restoring-divide trial step
  always_comb begin
    sum_s    = SW'(up_r[cnt_r*W +: W]) + SW'(low_r[cnt_r*W +: W]);
    prod_s   = PW'(sum_s) * PW'(pos_r[cnt_r*POS_W +: POS_W]);
    num_nx_s = num_r + NW'(prod_s);
    den_nx_s = den_r + DW'(sum_s);
    trial_s  = {rem_r, lo_r[POS_W-1]};
    ge_s     = (trial_s >= {1'b0, den_r});
    accept_s = start && ((state_r == IDLE) || (state_r == DONE));
`ifdef TR_DEFUZZY_ROUND_EN
    rnd_s    = ({rem_r, 1'b0} >= {1'b0, den_r});
`endif
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      up_r       <= '0;
      low_r      <= '0;
      pos_r      <= '0;
      num_r      <= '0;
      den_r      <= '0;
      rem_r      <= '0;
      lo_r       <= '0;
      quo_r      <= '0;
      cnt_r      <= '0;
      busy_r     <= 1'b0;
      valid_r    <= 1'b0;
      div_zero_r <= 1'b0;
      saida_r    <= '0;
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          state_r <= IDLE;
        end
        ACCUM: begin
          num_r <= num_nx_s;
          den_r <= den_nx_s;
          if (cnt_r == CW'(N_SETS - 1)) begin
            // Partial remainder starts as NUM's upper bits; it is below DEN because the centroid fits POS_W bits
            rem_r   <= num_nx_s[NW-1:POS_W];
            lo_r    <= num_nx_s[POS_W-1:0];
            quo_r   <= '0;
            cnt_r   <= '0;
            state_r <= DIV;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DIV: begin
          if (cnt_r < CW'(POS_W)) begin
            rem_r <= ge_s ? DW'(trial_s - {1'b0, den_r}) : trial_s[DW-1:0];
            lo_r  <= {lo_r[POS_W-2:0], 1'b0};
            quo_r <= {quo_r[POS_W-2:0], ge_s};
          end else begin
`ifdef TR_DEFUZZY_ROUND_EN
            if (rnd_s && (quo_r != {POS_W{1'b1}})) begin
              quo_r <= quo_r + POS_W'(1);
            end else begin
              quo_r <= quo_r;
            end
`else
            quo_r <= quo_r;
`endif
          end
          if (cnt_r == CW'(DIV_CYC - 1)) begin
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DONE: begin
          valid_r    <= 1'b1;
          div_zero_r <= (den_r == '0);
          saida_r    <= (den_r == '0) ? '0 : quo_r;
          state_r    <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
      // A new request overrides the DONE->IDLE step so results can stream back-to-back
      if (accept_s) begin
        up_r    <= fou_up;
        low_r   <= fou_low;
        pos_r   <= pos;
        num_r   <= '0;
        den_r   <= '0;
        cnt_r   <= '0;
        busy_r  <= 1'b1;
        state_r <= ACCUM;
      end
    end
  end

  assign busy     = busy_r;
  assign valid    = valid_r;
  assign div_zero = div_zero_r;
  assign saida    = saida_r;

endmodule
